// File: rtl/float_rounding.sv
//==============================================================================
// Module   : float_rounding
// Purpose  : Sequential round-to-nearest-even stage of the single-precision
//            floating-point adder. Captures a normalized mantissa (hidden bit
//            included), its biased exponent and the round/sticky bits. It then
//            rounds, renormalizes on carry-out and presents the result with a
//            valid flag two clock edges after capture.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            inValid    - operand strobe (honoured in IDLE and DONE only)
//            normMant   - normalized mantissa, bit MANT_W-1 is the hidden bit
//            currExp    - biased exponent of normMant
//            shiftRound - round (guard) bit, weight 1/2 LSB
//            sticky     - OR of all bits below the round bit
//            roundMant  - rounded mantissa, hidden bit included
//            roundExp   - rounded exponent
//            valid      - roundMant/roundExp are final
// Options  : FLOAT_ROUNDING_SAT_EN - when defined, exponent overflow saturates
//            to the largest finite value instead of producing +Inf.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module float_rounding #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  input  logic [MANT_W-1:0] normMant,
  input  logic [EXP_W-1:0]  currExp,
  input  logic              shiftRound,
  input  logic              sticky,
  output logic [MANT_W-1:0] roundMant,
  output logic [EXP_W-1:0]  roundExp,
  output logic              valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0]  C_EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  C_EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MANT_W-1:0] C_MANT_ONES = {MANT_W{1'b1}};
  // Add/sub unit control: this stage only ever uses it in add mode.
  localparam logic              C_SUB_MODE  = 1'b0;

  state_t state_q, state_d;

  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              rnd_q, rnd_d;
  logic              stk_q, stk_d;
  logic [MANT_W:0]   sum_q, sum_d;
  logic [MANT_W-1:0] roundMant_q, roundMant_d;
  logic [EXP_W-1:0]  roundExp_q, roundExp_d;
  logic              valid_q, valid_d;

  // Special operand classification on the captured values.
  logic w_is_inf_nan;
  logic w_is_zero;
  logic w_inc;
  logic [MANT_W:0] w_addend;
  logic [EXP_W-1:0] w_exp_inc;

  assign w_is_inf_nan = (exp_q == C_EXP_ONES);
  assign w_is_zero    = (mant_q == '0);

  // Round-to-nearest-even: increment when above half, or exactly half on an
  // odd mantissa. Special operands never increment.
  assign w_inc = rnd_q & (stk_q | mant_q[0]) & ~w_is_inf_nan & ~w_is_zero;

  // Operand B of the add/sub unit; in add mode it is the plain increment.
  assign w_addend  = {{MANT_W{1'b0}}, w_inc} ^ {(MANT_W+1){C_SUB_MODE}};
  // exp_q is never all-ones on the carry path, so this cannot wrap.
  assign w_exp_inc = exp_q + C_EXP_ONE;

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    rnd_d       = rnd_q;
    stk_d       = stk_q;
    sum_d       = sum_q;
    roundMant_d = roundMant_q;
    roundExp_d  = roundExp_q;
    valid_d     = valid_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (inValid) begin
          mant_d  = normMant;
          exp_d   = currExp;
          rnd_d   = shiftRound;
          stk_d   = sticky;
          valid_d = 1'b0;
          state_d = ROUND;
        end
      end

      ROUND: begin
        sum_d   = {1'b0, mant_q} + w_addend + {{MANT_W{1'b0}}, C_SUB_MODE};
        state_d = NORM;
      end

      NORM: begin
        if (w_is_inf_nan) begin
          // Inf/NaN pass through untouched (checked first so an all-ones
          // exponent with zero mantissa stays +Inf rather than becoming 0).
          roundMant_d = mant_q;
          roundExp_d  = exp_q;
        end else if (w_is_zero) begin
          roundMant_d = '0;
          roundExp_d  = '0;
        end else if (sum_q[MANT_W]) begin
          // Carry out of the mantissa: shift right one and bump exponent.
          if (w_exp_inc == C_EXP_ONES) begin
`ifdef FLOAT_ROUNDING_SAT_EN
            roundMant_d = C_MANT_ONES;
            roundExp_d  = C_EXP_ONES - C_EXP_ONE;
`else
            roundMant_d = '0;
            roundExp_d  = C_EXP_ONES;
`endif
          end else begin
            roundMant_d = sum_q[MANT_W:1];
            roundExp_d  = w_exp_inc;
          end
        end else begin
          roundMant_d = sum_q[MANT_W-1:0];
          roundExp_d  = exp_q;
        end
        valid_d = 1'b1;
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      rnd_q       <= 1'b0;
      stk_q       <= 1'b0;
      sum_q       <= '0;
      roundMant_q <= '0;
      roundExp_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      rnd_q       <= rnd_d;
      stk_q       <= stk_d;
      sum_q       <= sum_d;
      roundMant_q <= roundMant_d;
      roundExp_q  <= roundExp_d;
      valid_q     <= valid_d;
    end
  end

  assign roundMant = roundMant_q;
  assign roundExp  = roundExp_q;
  assign valid     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_float_rounding.sv
//==============================================================================
// Module   : tb_float_rounding
// Purpose  : Self-checking bench for float_rounding using a table of directed
//            vectors plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_float_rounding;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              inValid;
  logic [MANT_W-1:0] normMant;
  logic [EXP_W-1:0]  currExp;
  logic              shiftRound;
  logic              sticky;
  logic [MANT_W-1:0] roundMant;
  logic [EXP_W-1:0]  roundExp;
  logic              valid;

  int n_pass;
  int n_total;

  float_rounding #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .normMant  (normMant),
    .currExp   (currExp),
    .shiftRound(shiftRound),
    .sticky    (sticky),
    .roundMant (roundMant),
    .roundExp  (roundExp),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              rnd;
    logic              stk;
    logic [MANT_W-1:0] exp_mant;
    logic [EXP_W-1:0]  exp_exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Capture on edge k, then check valid low after k and k+1, result after k+2.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    normMant   = v.mant;
    currExp    = v.exp;
    shiftRound = v.rnd;
    sticky     = v.stk;
    inValid    = 1'b1;
    @(posedge clk); #1;
    inValid    = 1'b0;
    // Scramble inputs: they only need to be stable at the capture edge.
    normMant   = ~v.mant;
    currExp    = ~v.exp;
    check({tag, "_valid_k"}, {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_k1"}, {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_k2"}, {31'd0, valid}, 32'd1);
    check({tag, "_mant"}, {8'd0, roundMant}, {8'd0, v.exp_mant});
    check({tag, "_exp"}, {24'd0, roundExp}, {24'd0, v.exp_exp});
  endtask

  initial begin
    vecs[0]  = '{24'hC00001, 8'd130, 1'b0, 1'b1, 24'hC00001, 8'd130}; // sticky only
    vecs[1]  = '{24'hC00001, 8'd130, 1'b1, 1'b0, 24'hC00002, 8'd130}; // tie, odd
    vecs[2]  = '{24'hC00002, 8'd130, 1'b1, 1'b0, 24'hC00002, 8'd130}; // tie, even
    vecs[3]  = '{24'hFFFFFF, 8'd127, 1'b1, 1'b1, 24'h800000, 8'd128}; // carry-out
`ifdef FLOAT_ROUNDING_SAT_EN
    vecs[4]  = '{24'hFFFFFF, 8'd254, 1'b1, 1'b0, 24'hFFFFFF, 8'd254}; // overflow, saturate
`else
    vecs[4]  = '{24'hFFFFFF, 8'd254, 1'b1, 1'b0, 24'h000000, 8'd255}; // overflow, +Inf
`endif
    vecs[5]  = '{24'h000000, 8'd100, 1'b1, 1'b1, 24'h000000, 8'd0};   // zero mantissa
    vecs[6]  = '{24'h123456, 8'd255, 1'b1, 1'b1, 24'h123456, 8'd255}; // Inf/NaN pass
    vecs[7]  = '{24'h400001, 8'd50,  1'b1, 1'b1, 24'h400002, 8'd50};  // hidden bit clear
    vecs[8]  = '{24'hC00003, 8'd10,  1'b1, 1'b0, 24'hC00004, 8'd10};  // tie, odd carry chain
    vecs[9]  = '{24'hC00002, 8'd10,  1'b1, 1'b1, 24'hC00003, 8'd10};  // above half
    vecs[10] = '{24'hC00002, 8'd10,  1'b0, 1'b0, 24'hC00002, 8'd10};  // exact
    vecs[11] = '{24'h7FFFFF, 8'd20,  1'b1, 1'b1, 24'h800000, 8'd20};  // into hidden bit, no carry
    vecs[12] = '{24'hFFFFFE, 8'd254, 1'b1, 1'b1, 24'hFFFFFF, 8'd254}; // near overflow

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    inValid = 1'b0;
    normMant = '0;
    currExp = '0;
    shiftRound = 1'b0;
    sticky = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_mant", {8'd0, roundMant}, 32'd0);
    check("rst_exp", {24'd0, roundExp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back to back (every capture after the first is in DONE).
    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // DONE holds output and valid while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_mant", {8'd0, roundMant}, {8'd0, vecs[NVEC-1].exp_mant});
    check("hold_exp", {24'd0, roundExp}, {24'd0, vecs[NVEC-1].exp_exp});

    // inValid ignored in ROUND and NORM: strobe stays high for two cycles with
    // new data, but the first capture's result must appear.
    @(negedge clk);
    normMant = 24'hC00001; currExp = 8'd140; shiftRound = 1'b1; sticky = 1'b0;
    inValid = 1'b1;
    @(posedge clk); #1;                    // edge k: captured, now ROUND
    normMant = 24'hAAAAAA; currExp = 8'd7; shiftRound = 1'b0; sticky = 1'b0;
    @(posedge clk); #1;                    // edge k+1: ignored, now NORM
    inValid = 1'b0;
    @(posedge clk); #1;                    // edge k+2: result
    check("ign_valid", {31'd0, valid}, 32'd1);
    check("ign_mant", {8'd0, roundMant}, 32'h00C00002);
    check("ign_exp", {24'd0, roundExp}, 32'd140);

    // Reset pulsed while in NORM clears outputs immediately.
    @(negedge clk);
    normMant = 24'hFFFFFF; currExp = 8'd127; shiftRound = 1'b1; sticky = 1'b1;
    inValid = 1'b1;
    @(posedge clk); #1;                    // ROUND
    inValid = 1'b0;
    @(posedge clk); #2;                    // NORM
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_mant", {8'd0, roundMant}, 32'd0);
    check("arst_exp", {24'd0, roundExp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("discard_valid", {31'd0, valid}, 32'd0);
    check("discard_mant", {8'd0, roundMant}, 32'd0);

    // Zero mantissa after reset, then Inf pass-through from IDLE/DONE.
    run_vec(100, '{24'h000000, 8'd77, 1'b1, 1'b1, 24'h000000, 8'd0});
    run_vec(101, '{24'h000000, 8'd255, 1'b1, 1'b1, 24'h000000, 8'd255});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/float_rounding.md
# float_rounding

Sequential round-to-nearest-even stage of the single-precision floating-point adder datapath. Takes a normalized 24-bit mantissa (hidden bit included), its exponent, and the round and sticky bits from the alignment and normalization logic. Produces the rounded mantissa and exponent, renormalizing when rounding carries out of the mantissa. Sits between the normalizing barrel shifter and the adder's result register, and drives the adder's result-valid flag.

## Interface
- MANT_W, default 24: mantissa width, hidden bit included.
- EXP_W, default 8: biased exponent width.
- Clock: input, 1 bit. Sole clock; all state changes on its rising edge.
- Reset: input, 1 bit. Asynchronous, active-low.
- inValid: input, 1 bit. Strobe: operands valid this cycle.
- normMant: input, MANT_W bits. Normalized mantissa; bit MANT_W-1 is the hidden bit.
- currExp: input, EXP_W bits. Biased exponent of normMant.
- shiftRound: input, 1 bit. Round (guard) bit, weight ½ LSB.
- sticky: input, 1 bit. OR of all bits below the round bit.
- roundMant: output, MANT_W bits. Rounded mantissa, hidden bit included.
- roundExp: output, EXP_W bits. Rounded exponent.
- valid: output, 1 bit. roundMant and roundExp are final.

## Operation
- FSM states: IDLE, ROUND, NORM, DONE.
- Capture: inValid=1 in IDLE or DONE captures normMant, currExp, shiftRound and sticky, and moves to ROUND.
  - In ROUND or NORM, inValid is ignored; there is no queuing.
- ROUND: computes inc = shiftRound & (sticky | mant[0]), then forms the MANT_W+1-bit sum mant + inc with an add/sub unit in add mode. Moves to NORM.
- NORM:
  - If sum[MANT_W]=1, the result is sum>>1 and exp+1.
  - Otherwise the result is sum[MANT_W-1:0] with exp unchanged.
  - Registers outputs, sets valid, moves to DONE.
- Special cases, checked on the captured values:
  - Mantissa == 0: result is mantissa 0, exponent 0; no increment.
  - Exponent == all-ones (Inf/NaN): mantissa and exponent pass through unchanged; no increment.
  - Hidden bit clear, mantissa nonzero: rounded normally, no left shift. Left normalization is the upstream block's job.
- Overflow: exponent incremented to all-ones produces +Inf encoding (exponent all-ones, mantissa 0), unless the saturation option is enabled (see Configuration).
- Arithmetic is unsigned. The exponent increment never wraps past all-ones.

## Timing
- Reset low: state IDLE, roundMant=0, roundExp=0, valid=0, asynchronously. This holds even mid-operation, and the operation in flight is discarded.
- Latency: capture on edge k. Outputs are updated and valid goes high on edge k+2. The latency is fixed whether or not a carry occurs.
- valid stays high and outputs hold in DONE until the next capture edge. On that edge valid drops to 0.
- A back-to-back capture in DONE is allowed and costs one valid-low window of 2 cycles.
- Inputs need only be stable at the capture edge.

## Configuration
- FLOAT_ROUNDING_SAT_EN defined: exponent overflow saturates to the largest finite value (exponent all-ones minus 1, mantissa all-ones).
- FLOAT_ROUNDING_SAT_EN undefined (default): overflow produces the +Inf encoding (exponent all-ones, mantissa 0).
- All other behaviour is identical in both builds.

## Test plan
- Sticky only, no round: normMant=0xC00001, currExp=130, shiftRound=0, sticky=1. Expect roundMant=0xC00001, roundExp=130, valid=1 two edges after capture.
- Tie on an odd mantissa: normMant=0xC00001, shiftRound=1, sticky=0. Expect roundMant=0xC00002 (round to even).
- Tie on an even mantissa: normMant=0xC00002, shiftRound=1, sticky=0. Expect roundMant=0xC00002, unchanged.
- Carry-out: normMant=0xFFFFFF, currExp=127, shiftRound=1, sticky=1. Expect roundMant=0x800000, roundExp=128.
- Overflow: normMant=0xFFFFFF, currExp=254, shiftRound=1. Expect exponent 255 and mantissa 0 by default. With FLOAT_ROUNDING_SAT_EN, expect exponent 254 and mantissa 0xFFFFFF.
- Reset and special operands:
  - Reset pulsed low while in NORM: outputs go to 0 and valid to 0 immediately.
  - A later capture of mantissa 0 yields 0/0 with valid set.
  - currExp=255 passes its inputs through unchanged.
